// File: rtl/mul_seq_if.sv
// mul_seq_if: bundles the EX-stage multiply request and the regfile
// write-back signals of mul_seq.
//   master (EX side):    drives start_i, signed_i, opa_i, opb_i, annul_i;
//                        receives hi_o, lo_o, mul_we_o, stallreq_o, busy_o
//   slave  (multiplier): the mirror image of master
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             annul_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             mul_we_o;
  logic             stallreq_o;
  logic             busy_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i,
    input  hi_o, lo_o, mul_we_o, stallreq_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i,
    output hi_o, lo_o, mul_we_o, stallreq_o, busy_o
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: sequential WIDTH x WIDTH multiplier (radix-2 shift-add, one
// multiplier bit per cycle). The product is written to the register file
// multiply port (hi -> r31, lo -> r30) by a single-cycle write pulse.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   bus (slave)    start_i/signed_i/opa_i/opb_i/annul_i request from EX,
//                  hi_o/lo_o/mul_we_o result to the regfile,
//                  stallreq_o to the stall controller, busy_o status
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start_i; request accepted here
// S_CALC | one shift-add step per cycle, WIDTH cycles in total
// S_DONE | result on hi_o/lo_o, mul_we_o high for this single cycle
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mul_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               mul_we_q, mul_we_d;

  logic               accept;
  logic               zero_op;
  logic               last_step;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod_fin;

  // Request qualification and operand magnitudes. The most negative value
  // negates to itself, which is exactly its unsigned magnitude.
  assign accept    = (state_q == S_IDLE) && bus.start_i && !bus.annul_i;
  assign zero_op   = (bus.opa_i == '0) || (bus.opb_i == '0);
  assign mag_a     = (bus.signed_i && bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
  assign mag_b     = (bus.signed_i && bus.opb_i[WIDTH-1]) ? -bus.opb_i : bus.opb_i;
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // The multiplicand is kept unshifted; the shift by cnt is applied here so
  // the final step's contribution is included in the value written to hi/lo.
  assign acc_sum  = acc_q + (mplier_q[0] ? (mcand_q << cnt_q) : '0);
  assign prod_fin = neg_q ? -acc_sum : acc_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = zero_op ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.annul_i)    state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. The write pulse is suppressed by a same-cycle flush.
  always_comb begin
    bus.stallreq_o = !rst && (accept || (state_q == S_CALC));
    bus.busy_o     = (state_q != S_IDLE);
    bus.mul_we_o   = mul_we_q && !bus.annul_i;
    bus.hi_o       = hi_q;
    bus.lo_o       = lo_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mul_we_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (zero_op) begin
            hi_d     = '0;
            lo_d     = '0;
            mul_we_d = 1'b1;
          end else begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = bus.signed_i && (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
            acc_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      S_CALC: begin
        if (!bus.annul_i) begin
          acc_d    = acc_sum;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (last_step) begin
            hi_d     = prod_fin[2*WIDTH-1:WIDTH];
            lo_d     = prod_fin[WIDTH-1:0];
            mul_we_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mul_we_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mul_we_q <= mul_we_d;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq. Expected products come from a
// native-arithmetic reference and are queued with the cycle at which the
// write pulse is due; the monitor pops and compares on each mul_we pulse.
module tb_mul_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic prev_we;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } sb_t;

  sb_t sb_q[$];

  mul_seq_if #(.WIDTH(32)) bus ();

  mul_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Result monitor
  always @(negedge clk) begin
    if (bus.mul_we_o) begin
      check("we_consecutive", {63'b0, prev_we}, 64'd0);
      if (sb_q.size() == 0) begin
        check("we_unexpected", {63'b0, bus.mul_we_o}, 64'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("we_cycle", 64'(cyc), 64'(e.due));
        check("hi", {32'b0, bus.hi_o}, {32'b0, e.prod[63:32]});
        check("lo", {32'b0, bus.lo_o}, {32'b0, e.prod[31:0]});
      end
    end
    prev_we = bus.mul_we_o;
  end

  // Watchdog
  always @(posedge clk) begin
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle budget exceeded at cyc %0d", cyc);
      $fatal(1, "timeout");
    end
  end

  // Issue one multiply in the next cycle T, then check stall/busy through
  // the write cycle; the monitor checks the result itself.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat;
    sb_t e;
    lat = (a == 0 || b == 0) ? 1 : 33;
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.signed_i = s;
    bus.opa_i    = a;
    bus.opb_i    = b;
    e.prod = model(a, b, s);
    e.due  = cyc + lat;
    sb_q.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      check("stallreq", {63'b0, bus.stallreq_o}, {63'b0, (k < lat)});
      check("busy", {63'b0, bus.busy_o}, {63'b0, (k > 0)});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int t0;
    logic [31:0] hold_hi, hold_lo;
    n_checks = 0;
    n_fail   = 0;
    prev_we  = 1'b0;
    cyc      = 0;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    bus.annul_i  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", {32'b0, bus.hi_o}, 64'd0);
    check("rst_lo", {32'b0, bus.lo_o}, 64'd0);
    check("rst_we", {63'b0, bus.mul_we_o}, 64'd0);
    check("rst_busy", {63'b0, bus.busy_o}, 64'd0);
    bus.start_i = 1'b1;
    bus.opa_i   = 32'd5;
    bus.opb_i   = 32'd5;
    #1;
    check("rst_stall", {63'b0, bus.stallreq_o}, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed corner cases, back to back
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    run_op(32'h0, 32'h1234_5678, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0, 1'b1);
    run_op(32'h1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 6; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    drain();

    // Flush mid-operation, then a fresh multiply two cycles later
    hold_hi = bus.hi_o;
    hold_lo = bus.lo_o;
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.opa_i    = 32'd7;
    bus.opb_i    = 32'd9;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(negedge clk);
    check("annul_busy_before", {63'b0, bus.busy_o}, 64'd1);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    check("annul_cycle", 64'(cyc), 64'(t0 + 11));
    check("annul_idle", {63'b0, bus.busy_o}, 64'd0);
    check("annul_stall", {63'b0, bus.stallreq_o}, 64'd0);
    check("annul_hold_hi", {32'b0, bus.hi_o}, {32'b0, hold_hi});
    check("annul_hold_lo", {32'b0, bus.lo_o}, {32'b0, hold_lo});
    run_op(32'd6, 32'd7, 1'b0);
    drain();

    // Reset in the middle of an operation
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.opa_i    = 32'h0000_1234;
    bus.opb_i    = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", {63'b0, bus.stallreq_o}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_hi", {32'b0, bus.hi_o}, 64'd0);
    check("rst_mid_lo", {32'b0, bus.lo_o}, 64'd0);
    check("rst_mid_we", {63'b0, bus.mul_we_o}, 64'd0);
    check("rst_mid_busy", {63'b0, bus.busy_o}, 64'd0);
    check("rst_mid_stall2", {63'b0, bus.stallreq_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'd2, 32'd3, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32×32 multiplier in the EX stage, producing the 64-bit product written into the register file's multiply port (hi → r31, lo → r30). It accepts a start request from EX and computes signed or unsigned products by radix-2 shift-add over 32 cycles. While it runs, it stalls the pipeline through the stall controller, then pulses a single write-enable alongside the result.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  multiply request from EX; sampled only in IDLE.
- signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
- opa_i  input  WIDTH  multiplicand; sampled with start_i.
- opb_i  input  WIDTH  multiplier; sampled with start_i.
- annul_i  input  1  flush; aborts the current operation.
- hi_o  output  WIDTH  product[63:32]; drives regfile hi.
- lo_o  output  WIDTH  product[31:0]; drives regfile lo.
- mul_we_o  output  1  one-cycle write pulse; drives regfile mul_we.
- stallreq_o  output  1  pipeline stall request (combinational).
- busy_o  output  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1, annul_i=0, and both operands nonzero: latch the magnitudes, the sign flag and the multiplier. Clear the 64-bit accumulator and cnt (6 bits). Go to CALC.
  - start_i=1, annul_i=0, and opa_i==0 or opb_i==0: load product 0. Go directly to DONE.
  - start_i=1 with annul_i=1: ignored; stay in IDLE.
- Magnitudes:
  - signed_i=1: |x| as an unsigned WIDTH-bit value. 0x80000000 maps to 0x80000000.
  - signed_i=0: operand used as-is.
  - neg = signed_i & (opa_i[31] ^ opb_i[31]).
- CALC, each cycle:
  - If multiplier[0]: acc += mcand << cnt (64-bit add, no overflow possible).
  - Multiplier shifts right by 1; cnt increments.
  - The cycle in which cnt==31 completes: go to DONE.
- Entering DONE: hi_o:lo_o <= neg ? -acc : acc (64-bit two's-complement negate).
- DONE: mul_we_o=1 for exactly this cycle. Next state is IDLE. start_i is ignored in DONE.
- annul_i=1 in CALC or DONE: next state IDLE. mul_we_o=0 in that cycle and the next. hi_o/lo_o keep their previous values.
- stallreq_o = (state==IDLE & start_i & ~annul_i) | (state==CALC). It is low in DONE, so EX advances in the write cycle.
- hi_o/lo_o hold the last completed result until the next DONE; they are valid only while mul_we_o=1.
- Regfile consumer: in the mul_we cycle, r31/r30 take hi/lo over any same-cycle normal write to those registers.

## Timing
- Reset (rst=1 at an edge): state=IDLE, hi_o=0, lo_o=0, mul_we_o=0, busy_o=0, cnt=0, acc=0. stallreq_o=0 while rst=1.
- Reset mid-operation: abandons the operation with no write pulse.
- Normal latency, with start_i sampled at edge T in IDLE:
  - CALC during cycles T+1..T+32.
  - DONE in T+33, with mul_we_o=1 and the result on hi_o/lo_o.
  - IDLE in T+34.
  - stallreq_o is high during T..T+32.
- Zero-operand latency: DONE in T+1 with result 0. stallreq_o is high only in cycle T.
- Back-to-back: a new start_i is accepted in the cycle after DONE (IDLE). Throughput is one multiply per 34 cycles.
- mul_we_o is registered and never asserts for two consecutive cycles.

## Test plan
- Unsigned max: opa=0xFFFFFFFF, opb=0xFFFFFFFF, signed=0, start at T → mul_we=1 only at T+33; hi=0xFFFFFFFE, lo=0x00000001; stallreq high T..T+32.
- Signed mixed: opa=0xFFFFFFFD (−3), opb=5, signed=1 → at T+33 hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with signed=0 → hi=0x00000004, lo=0xFFFFFFF1.
- Signed corner: opa=opb=0x80000000, signed=1 → hi=0x40000000, lo=0x00000000. With opb=0x7FFFFFFF instead → hi=0xC0000000, lo=0x80000000.
- Zero shortcut: opa=0, opb=0x12345678 → mul_we at T+1, hi=lo=0; stallreq high only at T.
- Annul mid-op: start at T with 7×9, annul at T+10 → IDLE at T+11, no mul_we through T+40, hi/lo unchanged. A new start 6×7 at T+12 → hi=0, lo=42 at T+45.
- Reset mid-op: start at T, rst=1 at T+5 → all outputs 0 from T+6, no mul_we pulse. After release, 2×3 → lo=6 with normal latency.
